// File: rtl/uart_dbg_pkg.sv
// Shared constants, state encoding and argument-count helper for the UART debug responder.
// No logic and no latency; pure definitions.
// Backpressure is not applicable to this file.
package uart_dbg_pkg;

  localparam logic [7:0] CmdRead  = 8'h11;
  localparam logic [7:0] CmdWrite = 8'h12;
  localparam logic [7:0] CmdExec  = 8'h13;
  localparam logic [7:0] Ack      = 8'h06;
  localparam logic [7:0] Eot      = 8'h04;
  localparam logic [7:0] Eoc      = 8'h14;

  localparam logic [3:0] ReadArgs  = 4'd4;
  localparam logic [3:0] WriteArgs = 4'd8;
  localparam logic [3:0] ExecArgs  = 4'd4;

  typedef enum logic [2:0] {
    IDLE,
    ARGS,
    BUS_REQ,
    BUS_WAIT,
    RESP
  } uart_dbg_state_e;

  function automatic logic [3:0] arg_count(input logic [7:0] cmd);
    case (cmd)
      CmdWrite: return WriteArgs;
      CmdExec:  return ExecArgs;
      default:  return ReadArgs;
    endcase
  endfunction

endpackage

// File: rtl/uart_dbg_tx_ser.sv
// Reply serializer: holds up to 5 bytes (byte 0 in [7:0]) and emits them in order on tx_*.
// Latency: tx_valid_o rises the cycle after load_i.
// Backpressure: byte and index hold while tx_ready_i is low.
module uart_dbg_tx_ser (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [2:0]  len_i,
  input  logic [39:0] buf_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [39:0] buf_q, buf_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic        last;

  assign last       = (idx_q == len_q - 3'd1);
  assign done_o     = vld_q && tx_ready_i && last;
  assign tx_valid_o = vld_q;

  always_comb begin
    case (idx_q)
      3'd1:    tx_data_o = buf_q[15:8];
      3'd2:    tx_data_o = buf_q[23:16];
      3'd3:    tx_data_o = buf_q[31:24];
      3'd4:    tx_data_o = buf_q[39:32];
      default: tx_data_o = buf_q[7:0];
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    len_d = len_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (load_i) begin
      buf_d = buf_i;
      len_d = len_i;
      idx_d = 3'd0;
      vld_d = 1'b1;
    end else if (vld_q && tx_ready_i) begin
      if (last) begin
        vld_d = 1'b0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      len_q <= len_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/uart_dbg_responder.sv
// UART debug responder: host byte commands -> one 32-bit bus access or exec pulse -> reply bytes.
// Latency: req_o / exec pulse the cycle after the last argument byte; reply the cycle after rvalid_i.
// Backpressure: rx_ready_o low outside IDLE/ARGS; UART_DBG_TIMEOUT_EN adds an ARGS inter-byte timeout.
module uart_dbg_responder
  import uart_dbg_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 we_o,
  output logic [3:0]           be_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic                 err_i,
  output logic                 exec_valid_o,
  output logic [AddrWidth-1:0] exec_addr_o,
  output logic                 busy_o
);

  if (AddrWidth != 32 || DataWidth != 32 || TimeoutCycles < 1) begin : g_bad_param
    $error("uart_dbg_responder: unsupported parameter values");
  end

  uart_dbg_state_e      state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 exec_valid_q, exec_valid_d;
  logic [AddrWidth-1:0] exec_addr_q, exec_addr_d;
  logic                 rx_fire, take_rsp, tx_done;
  logic                 ld;
  logic [2:0]           ld_len;
  logic [39:0]          ld_buf;

`ifdef UART_DBG_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  assign rx_ready_o   = (state_q == IDLE) || (state_q == ARGS);
  assign rx_fire      = rx_valid_i && rx_ready_o;
  assign req_o        = (state_q == BUS_REQ);
  assign addr_o       = {addr_q[AddrWidth-1:2], 2'b00};
  assign we_o         = (cmd_q == CmdWrite);
  assign be_o         = 4'hF;
  assign wdata_o      = wdata_q;
  assign exec_valid_o = exec_valid_q;
  assign exec_addr_o  = exec_addr_q;
  assign busy_o       = (state_q != IDLE);

  // A response may arrive in the grant cycle itself, so BUS_REQ can skip BUS_WAIT.
  assign take_rsp = rvalid_i && ((state_q == BUS_REQ && gnt_i) || state_q == BUS_WAIT);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    exec_valid_d = 1'b0;
    exec_addr_d  = exec_addr_q;
    ld           = 1'b0;
    ld_len       = 3'd1;
    ld_buf       = {32'h0, Eot};
`ifdef UART_DBG_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == ARGS && !rx_fire) tmo_d = tmo_q + 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cmd_d = rx_data_i;
          cnt_d = 4'd0;
          if (rx_data_i == CmdRead || rx_data_i == CmdWrite || rx_data_i == CmdExec) begin
            state_d = ARGS;
          end else begin
            ld      = 1'b1;
            state_d = RESP;
          end
        end
      end
      ARGS: begin
        if (rx_fire) begin
          cnt_d = cnt_q + 4'd1;
          // Little-endian: each new byte enters at the top and walks down to [7:0].
          if (cnt_q < ReadArgs) addr_d = {rx_data_i, addr_q[AddrWidth-1:8]};
          else                  wdata_d = {rx_data_i, wdata_q[DataWidth-1:8]};
          if (cnt_d == arg_count(cmd_q)) begin
            if (cmd_q == CmdExec) begin
              exec_valid_d = 1'b1;
              exec_addr_d  = {rx_data_i, addr_q[AddrWidth-1:8]};
              ld           = 1'b1;
              ld_buf       = {32'h0, Ack};
              state_d      = RESP;
            end else begin
              state_d = BUS_REQ;
            end
          end
        end
`ifdef UART_DBG_TIMEOUT_EN
        else if (tmo_d == TmoW'(TimeoutCycles)) begin
          ld      = 1'b1;
          state_d = RESP;
        end
`endif
      end
      BUS_REQ:  if (gnt_i) state_d = BUS_WAIT;
      BUS_WAIT: state_d = BUS_WAIT;
      RESP:     if (tx_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (take_rsp) begin
      ld      = 1'b1;
      state_d = RESP;
      if (!err_i) begin
        ld_buf = {rdata_i, Ack};
        ld_len = (cmd_q == CmdWrite) ? 3'd1 : 3'd5;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      exec_valid_q <= 1'b0;
      exec_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      exec_valid_q <= exec_valid_d;
      exec_addr_q  <= exec_addr_d;
    end
  end

`ifdef UART_DBG_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  uart_dbg_tx_ser u_tx_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ld),
    .len_i      (ld_len),
    .buf_i      (ld_buf),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (tx_done)
  );

endmodule

// File: tb/tb_uart_dbg_responder.sv
// Directed bench for uart_dbg_responder: table of command vectors plus hand-written exec,
// reset-abort and (with UART_DBG_TIMEOUT_EN) timeout sequences.
module tb_uart_dbg_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b1;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'hFFFF_FFFF;
  logic        err_i = 1'b0;
  logic        exec_valid_o;
  logic [31:0] exec_addr_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  uart_dbg_responder #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(100)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .exec_valid_o(exec_valid_o), .exec_addr_o(exec_addr_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] tx_q[$];

  // Reply bytes are captured at the negedge preceding the handshake edge.
  always @(negedge clk_i) begin
    if (!rst_i && tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          gnt_dly;
    int          rv_dly;
    int          bp;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    int          exp_n;
    logic [39:0] exp_tx;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int gnt_dly,
                              input int rv_dly, input int bp, input logic exp_req, input logic exp_we,
                              input logic [31:0] exp_addr, input int exp_n, input logic [39:0] exp_tx);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.bp = bp; v.exp_req = exp_req; v.exp_we = exp_we;
    v.exp_addr = exp_addr; v.exp_n = exp_n; v.exp_tx = exp_tx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("rx_accept_bound", 64'(n), 64'd0);
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_reply(input string tag, input int exp_n, input logic [39:0] exp_tx);
    int k;
    logic [7:0] got;
    k = 0;
    while (tx_q.size() < exp_n && k < 100) begin
      tick();
      k++;
    end
    chk({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      chk($sformatf("%s_tx_byte%0d", tag, i), 64'(got), 64'(exp_tx[8*i +: 8]));
    end
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_idle_rx_ready"}, 64'(rx_ready_o), 64'd1);
    chk({tag, "_idle_tx_valid"}, 64'(tx_valid_o), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic ok;
    logic [7:0] d0;
    tx_q.delete();
    tx_ready_i = (v.bp == 0);
    send_byte(v.cmd);
    if (v.exp_req) begin
      for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
      if (v.exp_we) for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
      chk({tag, "_req_rise"}, 64'(req_o), 64'd1);
      chk({tag, "_addr"}, 64'(addr_o), 64'(v.exp_addr));
      chk({tag, "_we"}, 64'(we_o), 64'(v.exp_we));
      chk({tag, "_be"}, 64'(be_o), 64'hF);
      if (v.exp_we) chk({tag, "_wdata"}, 64'(wdata_o), 64'(v.wdata));
      chk({tag, "_rx_ready_bus"}, 64'(rx_ready_o), 64'd0);
      ok = 1'b1;
      for (int i = 0; i < v.gnt_dly; i++) begin
        tick();
        if (req_o !== 1'b1 || addr_o !== v.exp_addr || we_o !== v.exp_we) ok = 1'b0;
        if (v.exp_we && wdata_o !== v.wdata) ok = 1'b0;
      end
      if (v.gnt_dly > 0) chk({tag, "_req_hold"}, 64'(ok), 64'd1);
      gnt_i = 1'b1;
      if (v.rv_dly == 0) begin
        rvalid_i = 1'b1; rdata_i = v.rdata; err_i = v.err;
      end
      tick();
      gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'hFFFF_FFFF; err_i = 1'b0;
      chk({tag, "_req_drop"}, 64'(req_o), 64'd0);
      if (v.rv_dly > 0) begin
        repeat (v.rv_dly - 1) tick();
        chk({tag, "_tx_before_rvalid"}, 64'(tx_valid_o), 64'd0);
        rvalid_i = 1'b1; rdata_i = v.rdata; err_i = v.err;
        tick();
        rvalid_i = 1'b0; rdata_i = 32'hFFFF_FFFF; err_i = 1'b0;
      end
    end
    chk({tag, "_tx_valid_rise"}, 64'(tx_valid_o), 64'd1);
    chk({tag, "_first_byte"}, 64'(tx_data_o), 64'(v.exp_tx[7:0]));
    if (v.bp > 0) begin
      d0 = tx_data_o;
      ok = 1'b1;
      for (int i = 0; i < v.bp; i++) begin
        tick();
        if (tx_valid_o !== 1'b1 || tx_data_o !== d0 || rx_ready_o !== 1'b0) ok = 1'b0;
      end
      chk({tag, "_backpressure_hold"}, 64'(ok), 64'd1);
      tx_ready_i = 1'b1;
    end
    wait_reply(tag, v.exp_n, v.exp_tx);
  endtask

  initial begin
    //           cmd    addr           wdata          rdata          err gnt rv bp  req we  exp_addr       n  tx
    vecs[0] = mk(8'h11, 32'h1000_0000, 32'h0,         32'h1234_5678, 0, 0,  1, 0,  1, 0, 32'h1000_0000, 5, 40'h12345678_06);
    vecs[1] = mk(8'h12, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         0, 2,  0, 0,  1, 1, 32'h1000_0004, 1, 40'h06);
    vecs[2] = mk(8'h11, 32'h2000_0008, 32'h0,         32'hCAFE_F00D, 1, 1,  3, 0,  1, 0, 32'h2000_0008, 1, 40'h04);
    vecs[3] = mk(8'h55, 32'h0,         32'h0,         32'h0,         0, 0,  0, 0,  0, 0, 32'h0,         1, 40'h04);
    vecs[4] = mk(8'h12, 32'h0000_0100, 32'h0102_0304, 32'h0,         1, 0,  0, 0,  1, 1, 32'h0000_0100, 1, 40'h04);
    vecs[5] = mk(8'h11, 32'h8000_0003, 32'h0,         32'hA5C3_0FF0, 0, 3,  2, 0,  1, 0, 32'h8000_0000, 5, 40'hA5C30FF0_06);
    vecs[6] = mk(8'h06, 32'h0,         32'h0,         32'h0,         0, 0,  0, 0,  0, 0, 32'h0,         1, 40'h04);
    vecs[7] = mk(8'h11, 32'h0000_1000, 32'h0,         32'h8765_4321, 0, 0,  1, 20, 1, 0, 32'h0000_1000, 5, 40'h87654321_06);

    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_rx_ready", 64'(rx_ready_o), 64'd1);
    chk("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    chk("rst_tx_data", 64'(tx_data_o), 64'd0);
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    chk("rst_exec_valid", 64'(exec_valid_o), 64'd0);
    chk("rst_exec_addr", 64'(exec_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_be", 64'(be_o), 64'hF);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Exec: pulse and address in the cycle after the last byte, never a bus request.
    tx_q.delete();
    tx_ready_i = 1'b1;
    send_byte(8'h13);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    chk("exec_pulse", 64'(exec_valid_o), 64'd1);
    chk("exec_addr", 64'(exec_addr_o), 64'h1000_0080);
    chk("exec_no_req", 64'(req_o), 64'd0);
    chk("exec_tx_valid", 64'(tx_valid_o), 64'd1);
    tick();
    chk("exec_pulse_end", 64'(exec_valid_o), 64'd0);
    chk("exec_addr_held", 64'(exec_addr_o), 64'h1000_0080);
    chk("exec_no_req2", 64'(req_o), 64'd0);
    wait_reply("exec", 1, 40'h06);

    // Reset while an ungranted request is pending.
    tx_q.delete();
    send_byte(8'h11);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h30);
    chk("rstmid_req_before", 64'(req_o), 64'd1);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstmid_req", 64'(req_o), 64'd0);
    chk("rstmid_busy", 64'(busy_o), 64'd0);
    chk("rstmid_rx_ready", 64'(rx_ready_o), 64'd1);
    chk("rstmid_tx_valid", 64'(tx_valid_o), 64'd0);
    chk("rstmid_addr", 64'(addr_o), 64'd0);
    repeat (5) tick();
    chk("rstmid_no_tx", 64'(tx_q.size()), 64'd0);
    run_vec(vecs[0], "post_rst");

`ifdef UART_DBG_TIMEOUT_EN
    begin
      int k;
      tx_q.delete();
      send_byte(8'h11);
      send_byte(8'h00);
      k = 0;
      while (!tx_valid_o && k < 300) begin
        tick();
        k++;
      end
      chk("tmo_delay_in_range", 64'(k >= 100 && k <= 101), 64'd1);
      chk("tmo_byte", 64'(tx_data_o), 64'h04);
      wait_reply("tmo", 1, 40'h04);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
